mips_cpu_muldiv_seq: RTL and testbench
======================================

Name: mips_cpu_muldiv_seq

Overview:
- Iterative, multi-cycle HI/LO producer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Owns the architectural HI and LO registers, which feed the ALU's MFHI/MFLO result path.
- Uses a start/busy/done handshake. Control logic stalls MFHI/MFLO and further HI/LO ops while busy is high.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- ITER_W, $clog2(DATA_WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  4  operation code (pkg enum): NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; others are NOP.
- a  input  DATA_WIDTH  rs operand (multiplicand / dividend / MTxx source).
- b  input  DATA_WIDTH  rt operand (multiplier / divisor).
- flush  input  1  abort in-flight op (exception/pipeline flush).
- busy  output  1  high while an arithmetic op is in flight.
- done  output  1  one-cycle pulse, HI/LO updated by an arithmetic op.
- hi  output  DATA_WIDTH  architectural HI register.
- lo  output  DATA_WIDTH  architectural LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. A reset mid-operation discards the operation.
- FSM states: IDLE, CALC, FIX. busy = (state != IDLE). done is registered.
- Acceptance: at a rising edge with state=IDLE, start=1, flush=0.
  - MTHI/MTLO: write a into hi/lo at that edge; busy stays 0; no done pulse.
  - MULT/MULTU/DIV/DIVU: latch operands into internal registers. For signed ops, latch magnitudes plus a result-sign flag. Go to CALC with counter=0.
  - NOP or reserved codes: no effect.
- CALC: one iteration per edge, DATA_WIDTH iterations total.
  - Multiply: radix-2 shift-add on the 2*DATA_WIDTH product.
  - Divide: restoring shift-subtract.
  - After the iteration with counter=DATA_WIDTH-1, go to FIX.
- FIX: one edge. Apply sign correction and write hi/lo. Go to IDLE and set done=1 for exactly one cycle.
- Latency: taking acceptance edge = E0, busy is high from E0 to E33 (33 cycles). hi/lo are valid and done is high in the cycle after E33. This latency is fixed for all operands, including zero divisor.
- Multiply results: {hi,lo} = full 64-bit product. MULT is signed two's complement; MULTU is unsigned.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - Divide by zero (b=0), DIV and DIVU: hi=a (original), lo=0xFFFFFFFF, with normal 33-cycle latency.
- start while busy=1: ignored, with no side effect. Simulation assertion flags start=1 with op!=NOP while busy.
- flush=1:
  - In CALC or FIX: go to IDLE at the next edge. hi/lo are unchanged and no done pulse is issued.
  - In IDLE: suppresses acceptance that edge.
  - flush beats FIX completion on the same edge.
- hi/lo change only on a FIX completion, MTHI/MTLO, or reset. They hold their prior values throughout CALC, so a read during busy returns stale data (control must stall).

Decomposition:
- Package mips_cpu_muldiv_pkg holds:
  - op_t enum (4-bit codes above);
  - state_t enum (IDLE, CALC, FIX);
  - localparam MULDIV_ITERS = DATA_WIDTH;
  - localparam DIV0_LO = all-ones.
- Sub-module mips_cpu_muldiv_core is the iterative datapath. It holds the operand/accumulator/partial-remainder registers and the one-step shift-add/shift-subtract logic, driven by step and load strobes.
- The top level holds the FSM, counter, sign handling, HI/LO registers and handshake.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high exactly 33 cycles, then a single done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 -> hi=0x00000007, lo=0xFFFFFFFF, same latency.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> each visible the cycle after acceptance; busy never rises; no done.
- DIVU 100/7 started, then start with MULT issued at cycle 5 -> MULT ignored; final hi=2, lo=14.
- Abort cases:
  - MULTU started, flush at cycle 10 -> busy low next cycle, no done, hi/lo keep prior values.
  - reset asserted mid-CALC -> hi=lo=0, busy=0 immediately (async).

Source files
------------

// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg
//   Shared types and constants for the iterative HI/LO multiply/divide unit.
//   op_t    : 4-bit operation codes presented on the request bus.
//   state_t : sequencer states (IDLE -> CALC -> FIX -> IDLE).
package mips_cpu_muldiv_pkg;

    localparam int MULDIV_DATA_WIDTH = 32;
    localparam int MULDIV_ITERS      = MULDIV_DATA_WIDTH;

    // LO result of any divide by zero.
    localparam logic [MULDIV_DATA_WIDTH-1:0] DIV0_LO = '1;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mips_cpu_muldiv_seq_if.sv
// mips_cpu_muldiv_seq_if
//   Request/response bundle between pipeline control and the HI/LO unit.
//   master (control): drives start, op, a, b, flush; observes busy, done, hi, lo.
//   slave  (unit)   : the reverse.
interface mips_cpu_muldiv_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_core.sv
// mips_cpu_muldiv_core
//   Unsigned one-bit-per-step datapath shared by multiply and divide.
//   load      : mcand <= mcand_in, acc <= {0, acc_lo_in}
//   step      : one shift-add (multiply) or restoring shift-subtract (divide)
//   is_div    : selects the divide step
//   mcand_in  : multiplicand magnitude, or divisor magnitude for divide
//   acc_lo_in : multiplier magnitude, or dividend magnitude for divide
//   acc       : multiply -> 2W product; divide -> {remainder, quotient}
module mips_cpu_muldiv_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    step,
    input  logic                    is_div,
    input  logic [DATA_WIDTH-1:0]   mcand_in,
    input  logic [DATA_WIDTH-1:0]   acc_lo_in,
    output logic [2*DATA_WIDTH-1:0] acc
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] acc_q,   acc_d;
    logic [W:0]     mul_sum;
    logic [W:0]     div_upper;
    logic [W:0]     div_trial;

    always_comb begin
        // Multiply: conditionally add into the upper half, then shift the
        // whole accumulator right; the multiplier drains out of the bottom.
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        // Divide: partial remainder shifted left with the next dividend bit.
        // A clear MSB on the trial difference means it fits (restore otherwise).
        div_upper = acc_q[2*W-1:W-1];
        div_trial = div_upper - {1'b0, mcand_q};

        // NOTE: every always_comb output is given a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        mcand_d = mcand_q;
        acc_d   = acc_q;
        if (load) begin
            mcand_d = mcand_in;
            acc_d   = {{W{1'b0}}, acc_lo_in};
        end else if (step) begin
            if (!is_div) begin
                acc_d = {mul_sum, acc_q[W-1:1]};
            end else if (!div_trial[W]) begin
                acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_d = {div_upper[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end
    end

    // NOTE: the datapath registers are reset too; they are few, and a known
    // value after reset keeps simulation free of X on the result path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq
//   Iterative HI/LO producer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of mips_cpu_muldiv_seq_if (start/op/a/b/flush in,
//           busy/done/hi/lo out). Arithmetic ops hold busy for 33 cycles
//           and then pulse done with hi/lo updated; MTHI/MTLO write at once.
module mips_cpu_muldiv_seq
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MULDIV_DATA_WIDTH,
    parameter int ITER_W     = $clog2(DATA_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_cpu_muldiv_seq_if.slave    bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(W - 1);

    state_t         state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           done_q, done_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;       // product / quotient must be negated
    logic           rem_neg_q, rem_neg_d; // remainder takes dividend's sign
    logic           div0_q, div0_d;

    logic           load, step;
    logic           signed_op, div_op;
    logic [W-1:0]   abs_a, abs_b;
    logic [2*W-1:0] core_acc;

    mips_cpu_muldiv_core #(.DATA_WIDTH(W)) u_core (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load),
        .step      (step),
        .is_div    (is_div_q),
        .mcand_in  (div_op ? abs_b : abs_a),
        .acc_lo_in (div_op ? abs_a : abs_b),
        .acc       (core_acc)
    );

    always_comb begin
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        abs_a     = (signed_op && bus.a[W-1]) ? -bus.a : bus.a;
        abs_b     = (signed_op && bus.b[W-1]) ? -bus.b : bus.b;

        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        load      = 1'b0;
        step      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load      = 1'b1;
                            is_div_d  = div_op;
                            neg_d     = signed_op && (bus.a[W-1] ^ bus.b[W-1]);
                            rem_neg_d = signed_op && bus.a[W-1];
                            div0_d    = (bus.b == '0);
                            cnt_d     = '0;
                            state_d   = ST_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + ITER_W'(1);
                    if (cnt_q == LAST_ITER) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                // A flush on the completion edge still discards the result.
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_neg_q ? -core_acc[2*W-1:W] : core_acc[2*W-1:W];
                        // Magnitude quotient is all-ones for b=0; the sign fix
                        // would turn it into 1, so the constant is forced.
                        lo_d = div0_q ? W'(DIV0_LO)
                                      : (neg_q ? -core_acc[W-1:0] : core_acc[W-1:0]);
                    end else begin
                        {hi_d, lo_d} = neg_q ? -core_acc : core_acc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Control should stall rather than issue while busy; such requests are dropped.
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!reset)
        !(bus.busy && bus.start && (bus.op != OP_NOP))
    ) else $warning("muldiv: request while busy was dropped");
endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// tb_mips_cpu_muldiv_seq
//   Directed plus randomized checks of the HI/LO unit against a plain
//   arithmetic reference model.
module tb_mips_cpu_muldiv_seq;
    import mips_cpu_muldiv_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mips_cpu_muldiv_seq_if #(.DATA_WIDTH(W)) bus ();

    mips_cpu_muldiv_seq #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        int     sa, sb;
        longint p;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                return 64'(p);
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {exp_hi, exp_lo};
        endcase
    endfunction

    // Issue an arithmetic op and follow it to completion. inject_at >= 0 drives
    // a competing request that many cycles after acceptance.
    task automatic run_arith(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int inject_at);
        logic [63:0] exp;
        logic        done_early, stale_bad;
        int          n;
        exp        = model(op, a, b);
        done_early = 1'b0;
        stale_bad  = 1'b0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.done !== 1'b0) done_early = 1'b1;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo) stale_bad = 1'b1;
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.op    = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MTHI;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end else begin
                bus.start = 1'b0;
                bus.op    = OP_NOP;
            end
            tick();
            n++;
        end
        bus.start = 1'b0; bus.op = OP_NOP;
        check($sformatf("%s busy_cycles", tag), 64'(n), 64'd33);
        check($sformatf("%s no_early_done", tag), 64'(done_early), 64'd0);
        check($sformatf("%s hilo_stale_while_busy", tag), 64'(stale_bad), 64'd0);
        check($sformatf("%s done", tag), 64'(bus.done), 64'd1);
        check($sformatf("%s hi", tag), 64'(bus.hi), 64'(exp[63:32]));
        check($sformatf("%s lo", tag), 64'(bus.lo), 64'(exp[31:0]));
        exp_hi = exp[63:32];
        exp_lo = exp[31:0];
        tick();
        check($sformatf("%s done_single", tag), 64'(bus.done), 64'd0);
    endtask

    task automatic run_mt(input string tag, input logic [3:0] op, input logic [W-1:0] a);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = $urandom;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        if (op == OP_MTHI) exp_hi = a;
        if (op == OP_MTLO) exp_lo = a;
        check($sformatf("%s hi", tag), 64'(bus.hi), 64'(exp_hi));
        check($sformatf("%s lo", tag), 64'(bus.lo), 64'(exp_lo));
        check($sformatf("%s busy", tag), 64'(bus.busy), 64'd0);
        check($sformatf("%s done", tag), 64'(bus.done), 64'd0);
        tick();
        check($sformatf("%s done_later", tag), 64'(bus.done), 64'd0);
    endtask

    // Start an op, flush it k cycles after acceptance, expect no effect.
    task automatic run_abort(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int k);
        logic done_seen;
        done_seen = 1'b0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        repeat (k) tick();
        check($sformatf("%s busy_before_flush", tag), 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check($sformatf("%s busy_after_flush", tag), 64'(bus.busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (bus.done !== 1'b0) done_seen = 1'b1;
            tick();
        end
        check($sformatf("%s no_done", tag), 64'(done_seen), 64'd0);
        check($sformatf("%s hi", tag), 64'(bus.hi), 64'(exp_hi));
        check($sformatf("%s lo", tag), 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        logic [3:0]   ops [6];
        logic [3:0]   op;
        logic [W-1:0] ra, rb, hold_hi;

        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
        bus.start = 1'b0; bus.op = OP_NOP; bus.a = '0; bus.b = '0; bus.flush = 1'b0;

        #1 rst_n = 1'b0;
        #11;
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        run_arith("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("multu_max hi const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max lo const", 64'(bus.lo), 64'h0000_0000_0000_0001);
        run_arith("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, -1);
        check("mult_neg3x5 lo const", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);
        run_arith("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_neg7by2 lo const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        run_arith("divu_by0", OP_DIVU, 32'd7, 32'd0, -1);
        run_arith("div_neg_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, -1);
        run_arith("div_min_by_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_arith("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, -1);

        run_mt("mthi", OP_MTHI, 32'h1234_5678);
        run_mt("mtlo", OP_MTLO, 32'h9ABC_DEF0);

        run_arith("divu_100by7_inject", OP_DIVU, 32'd100, 32'd7, 5);
        check("divu_100by7 hi const", 64'(bus.hi), 64'd2);
        check("divu_100by7 lo const", 64'(bus.lo), 64'd14);

        // Flush in IDLE suppresses acceptance; a reserved code does nothing.
        hold_hi = exp_hi;
        bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEAD_BEEF; bus.flush = 1'b1;
        tick();
        bus.op = OP_MULT;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP; bus.flush = 1'b0;
        check("idle_flush hi", 64'(bus.hi), 64'(hold_hi));
        check("idle_flush busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b1; bus.op = 4'd9; bus.a = 32'hCAFE_F00D;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        check("reserved busy", 64'(bus.busy), 64'd0);
        check("reserved hi", 64'(bus.hi), 64'(exp_hi));
        check("reserved lo", 64'(bus.lo), 64'(exp_lo));

        run_abort("flush_calc", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 10);
        run_abort("flush_fix", OP_DIV, 32'hFFFF_FF00, 32'd3, 32);

        // Asynchronous reset in the middle of CALC.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd1000; bus.b = 32'd1000;
        tick();
        bus.start = 1'b0; bus.op = OP_NOP;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset hi", 64'(bus.hi), 64'd0);
        check("async_reset lo", 64'(bus.lo), 64'd0);
        check("async_reset busy", 64'(bus.busy), 64'd0);
        check("async_reset done", 64'(bus.done), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk) rst_n = 1'b1;
        tick();

        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 5)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            if (op == OP_MTHI || op == OP_MTLO)
                run_mt($sformatf("rand%0d_mt", i), op, ra);
            else
                run_arith($sformatf("rand%0d", i), op, ra, rb,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
